// File: rtl/rvc_fetch_aligner.sv
// Halfword realignment queue between fetch and decode: extracts 16/32-bit
// instructions at any halfword alignment, tracks the head PC, valid/ready to decode.
module rvc_fetch_aligner #(
    parameter int          FETCH_HW = 2,
    parameter int          BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear_state,
    input  logic [31:0]                 redirect_pc,
    input  logic                        fetch_valid,
    output logic                        fetch_ready,
    input  logic [16*FETCH_HW-1:0]      fetch_data,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [31:0]                 instr,
    output logic [31:0]                 instr_pc,
    output logic                        instr_is_compressed,
    output logic                        stall_compressed,
    output logic [$clog2(BUF_HW+1)-1:0] hw_count
);
    localparam int CW = $clog2(BUF_HW + 1);
    localparam int PW = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
    localparam int DW = $clog2(FETCH_HW);
    localparam logic [CW-1:0] READY_MAX = CW'(BUF_HW - FETCH_HW);
    localparam logic [CW-1:0] FETCH_CNT = CW'(FETCH_HW);

    logic [15:0]   q [BUF_HW];
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] count;
    logic [31:0]   head_pc;
    logic [DW-1:0] drop_off;

    logic [PW-1:0] rp_nxt1;
    logic          is_c;
    logic [CW-1:0] need, added;
    logic          accept, consume;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = (int'(p) + n) % BUF_HW;
        return s[PW-1:0];
    endfunction

    assign rp_nxt1 = ptr_add(rp, 1);
    assign is_c    = (q[rp][1:0] != 2'b11);
    assign need    = is_c ? CW'(1) : CW'(2);
    assign added   = FETCH_CNT - CW'(drop_off);

    assign fetch_ready         = (count <= READY_MAX);
    assign instr_valid         = (count >= need);
    assign accept              = fetch_valid && fetch_ready;
    assign consume             = instr_valid && instr_ready;
    assign instr               = is_c ? {16'h0, q[rp]} : {q[rp_nxt1], q[rp]};
    assign instr_pc            = head_pc;
    assign instr_is_compressed = is_c;
    assign stall_compressed    = (count == CW'(1)) && !is_c;
    assign hw_count            = count;

    // Clear wins over any same-cycle accept or consume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rp       <= '0;
            wp       <= '0;
            count    <= '0;
            head_pc  <= RESET_PC;
            drop_off <= RESET_PC[DW:1];
        end else if (clear_state) begin
            rp       <= '0;
            wp       <= '0;
            count    <= '0;
            head_pc  <= redirect_pc;
            drop_off <= redirect_pc[DW:1];
        end else begin
            if (accept) begin
                wp       <= ptr_add(wp, int'(added));
                drop_off <= '0;
            end
            if (consume) begin
                rp      <= ptr_add(rp, int'(need));
                head_pc <= head_pc + (32'(need) << 1);
            end
            count <= count + (accept ? added : '0) - (consume ? need : '0);
        end
    end

    // Halfwords below drop_off precede the redirect target and are discarded.
    always_ff @(posedge clk) begin
        if (accept && !clear_state) begin
            for (int i = 0; i < FETCH_HW; i++) begin
                if (i >= int'(drop_off))
                    q[ptr_add(wp, i - int'(drop_off))] <= fetch_data[16*i +: 16];
            end
        end
    end
endmodule
